// File: rtl/decode_issue_buffer_pkg.sv
// Shared definitions for the decode/issue buffer: default geometry, the packed
// instruction payload layout and a small lane-run helper.
package decode_issue_buffer_pkg;

  localparam int LANES_DEF   = 2;
  localparam int DEPTH_DEF   = 8;

  localparam int WIDTH_PC    = 32;
  localparam int WIDTH_INST  = 32;
  localparam int WIDTH_UOP   = 16;
  localparam int WIDTH_IMM   = 32;
  localparam int WIDTH_REG   = 5;
  localparam int WIDTH_ECODE = 6;
  localparam int WIDTH_RSVD  = 160 - (WIDTH_PC + WIDTH_INST + WIDTH_UOP + WIDTH_IMM
                                      + 3 * WIDTH_REG + 1 + WIDTH_ECODE);

  // One decoded instruction; pc sits in the least-significant bits.
  typedef struct packed {
    logic [WIDTH_RSVD-1:0]  rsvd;
    logic                   excp;
    logic [WIDTH_ECODE-1:0] ecode;
    logic [WIDTH_REG-1:0]   rk;
    logic [WIDTH_REG-1:0]   rj;
    logic [WIDTH_REG-1:0]   rd;
    logic [WIDTH_IMM-1:0]   imm;
    logic [WIDTH_UOP-1:0]   uop;
    logic [WIDTH_INST-1:0]  inst;
    logic [WIDTH_PC-1:0]    pc;
  } payload_t;

  localparam int PAYLOAD_W_DEF = $bits(payload_t);

  // Length of the run of set bits starting at bit 0 (up to four lanes).
  function automatic logic [2:0] lead_run4(input logic [3:0] v);
    logic [2:0] r;
    casez (v)
      4'b1111: r = 3'd4;
      4'b?111: r = 3'd3;
      4'b??11: r = 3'd2;
      4'b???1: r = 3'd1;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_issue_buffer_issue_prefix_mask.sv
// Issue-group selection: which of the oldest LANES entries may issue together,
// and how many of them the consumer actually takes this cycle.
module issue_prefix_mask
  import decode_issue_buffer_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int CNT_W = 4
) (
  input  logic [CNT_W-1:0] count,
  input  logic [LANES-1:0] win_priv,
  input  logic [LANES-1:0] out_ready,
  output logic [LANES-1:0] issue_vld,
  output logic [CNT_W-1:0] deq_cnt
);

  // A priv entry closes the group: it may only sit in lane 0, and nothing
  // younger than a non-priv lane-0 entry may join past a priv entry.
  always_comb begin
    logic blocked;
    blocked   = 1'b0;
    issue_vld = '0;
    for (int k = 0; k < LANES; k++) begin
      blocked      = blocked | win_priv[k];
      issue_vld[k] = (count > CNT_W'(k)) & ((k == 0) | ~blocked);
    end
  end

  // Dequeue only the leading run of lanes that are both valid and accepted.
  always_comb begin
    logic [3:0] take4;
    take4              = '0;
    take4[LANES-1:0]   = issue_vld & out_ready;
    deq_cnt            = CNT_W'(lead_run4(take4));
  end

endmodule

// File: rtl/decode_issue_buffer.sv
// Multi-lane decode/issue circular buffer. Accepts up to LANES instructions
// per cycle, presents the oldest entries one cycle later, and keeps priv
// instructions isolated in their own issue group.
module decode_issue_buffer
  import decode_issue_buffer_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         flush,
  input  logic [LANES-1:0]             in_valid,
  input  logic [LANES-1:0]             in_priv,
  input  logic [LANES*PAYLOAD_W-1:0]   in_payload,
  output logic                         in_ready,
  output logic [LANES-1:0]             out_valid,
  output logic [LANES-1:0]             out_priv,
  output logic [LANES*PAYLOAD_W-1:0]   out_payload,
  input  logic [LANES-1:0]             out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PAYLOAD_W-1:0] ent_pay_p1 [DEPTH];
  logic [DEPTH-1:0]     ent_priv_p1;
  logic [PTR_W-1:0]     head_p1;
  logic [PTR_W-1:0]     tail_p1;
  logic [CNT_W-1:0]     count_p1;

  logic                 enq_go;
  logic [CNT_W-1:0]     enq_cnt;
  logic [CNT_W-1:0]     deq_cnt;
  logic [LANES-1:0]     win_priv;
  logic [LANES-1:0]     issue_vld;

  // Space check uses only the registered occupancy; a same-cycle dequeue
  // never frees room for this cycle's group.
  assign in_ready = (count_p1 <= CNT_W'(DEPTH - LANES));
  assign count    = count_p1;
  assign empty    = (count_p1 == '0);
  assign full     = (count_p1 == CNT_W'(DEPTH));

  // Enqueue size is the leading contiguous prefix of in_valid.
  always_comb begin
    logic [3:0] in_vld4;
    in_vld4            = '0;
    in_vld4[LANES-1:0] = in_valid;
    enq_go             = in_ready & in_valid[0];
    enq_cnt            = enq_go ? CNT_W'(lead_run4(in_vld4)) : '0;
  end

  // Priv flags of the LANES oldest slots, wrapping around the ring.
  always_comb begin
    win_priv = '0;
    for (int k = 0; k < LANES; k++) begin
      win_priv[k] = ent_priv_p1[head_p1 + PTR_W'(k)];
    end
  end

  issue_prefix_mask #(
    .LANES (LANES),
    .CNT_W (CNT_W)
  ) u_issue_prefix_mask (
    .count     (count_p1),
    .win_priv  (win_priv),
    .out_ready (out_ready),
    .issue_vld (issue_vld),
    .deq_cnt   (deq_cnt)
  );

  // Present the oldest entries; lanes not issuing are forced to zero so the
  // unreset storage never leaks onto the outputs.
  always_comb begin
    out_valid   = issue_vld;
    out_priv    = '0;
    out_payload = '0;
    for (int k = 0; k < LANES; k++) begin
      if (issue_vld[k]) begin
        out_priv[k]                           = ent_priv_p1[head_p1 + PTR_W'(k)];
        out_payload[k*PAYLOAD_W +: PAYLOAD_W] = ent_pay_p1[head_p1 + PTR_W'(k)];
      end
    end
  end

  // Pointer and occupancy state; flush and reset both empty the ring.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      head_p1  <= '0;
      tail_p1  <= '0;
      count_p1 <= '0;
    end else if (flush) begin
      head_p1  <= '0;
      tail_p1  <= '0;
      count_p1 <= '0;
    end else begin
      head_p1  <= head_p1 + PTR_W'(deq_cnt);
      tail_p1  <= tail_p1 + PTR_W'(enq_cnt);
      count_p1 <= count_p1 + enq_cnt - deq_cnt;
    end
  end

  // Entry storage, written in lane order at the tail; not reset.
  always_ff @(posedge aclk) begin
    if (!flush) begin
      for (int k = 0; k < LANES; k++) begin
        if (CNT_W'(k) < enq_cnt) begin
          ent_pay_p1[tail_p1 + PTR_W'(k)]  <= in_payload[k*PAYLOAD_W +: PAYLOAD_W];
          ent_priv_p1[tail_p1 + PTR_W'(k)] <= in_priv[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Bench for decode_issue_buffer (LANES=2, DEPTH=8, PAYLOAD_W=32): a directed
// vector table, hand-written corner sequences and random traffic, all checked
// against a queue-based reference model.
module tb_decode_issue_buffer;

  logic        aclk = 1'b0;
  logic        areset = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  in_valid = '0;
  logic [1:0]  in_priv = '0;
  logic [63:0] in_payload = '0;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [1:0]  out_priv;
  logic [63:0] out_payload;
  logic [1:0]  out_ready = '0;
  logic [3:0]  count;
  logic        empty;
  logic        full;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of buffered entries, oldest at index 0.
  logic [31:0] mq_pay[$];
  logic        mq_priv[$];

  typedef struct {
    logic [1:0]  iv;
    logic [1:0]  ip;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [1:0]  ordy;
    logic [1:0]  ev;
    logic [1:0]  epr;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [3:0]  ecnt;
  } vec_t;

  vec_t tbl [8];

  decode_issue_buffer #(
    .LANES     (2),
    .DEPTH     (8),
    .PAYLOAD_W (32)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_priv     (in_priv),
    .in_payload  (in_payload),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_priv    (out_priv),
    .out_payload (out_payload),
    .out_ready   (out_ready),
    .count       (count),
    .empty       (empty),
    .full        (full)
  );

  always #5 aclk = ~aclk;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] iv, input logic [1:0] ip, input logic [31:0] p0,
                       input logic [31:0] p1, input logic [1:0] ordy, input logic fl);
    in_valid   = iv;
    in_priv    = ip;
    in_payload = {p1, p0};
    out_ready  = ordy;
    flush      = fl;
  endtask

  // Which lanes the model says may issue: the oldest always (if present),
  // the second only if neither it nor the oldest is priv.
  function automatic logic [1:0] model_valid();
    logic [1:0] ev;
    ev = 2'b00;
    if (mq_pay.size() > 0) ev[0] = 1'b1;
    if (mq_pay.size() > 1) begin
      if (!mq_priv[0] && !mq_priv[1]) ev[1] = 1'b1;
    end
    return ev;
  endfunction

  task automatic model_check(input string tag);
    int          n;
    logic [1:0]  ev;
    logic [1:0]  epr;
    logic [31:0] e0;
    logic [31:0] e1;
    n   = mq_pay.size();
    ev  = model_valid();
    epr = 2'b00;
    e0  = '0;
    e1  = '0;
    if (ev[0]) begin e0 = mq_pay[0]; epr[0] = mq_priv[0]; end
    if (ev[1]) begin e1 = mq_pay[1]; epr[1] = mq_priv[1]; end
    chk({tag, ".count"},    64'(count),              64'(n));
    chk({tag, ".empty"},    64'(empty),              64'(n == 0));
    chk({tag, ".full"},     64'(full),               64'(n == 8));
    chk({tag, ".in_ready"}, 64'(in_ready),           64'(n <= 6));
    chk({tag, ".valid"},    64'(out_valid),          64'(ev));
    chk({tag, ".priv"},     64'(out_priv),           64'(epr));
    chk({tag, ".lane0"},    64'(out_payload[31:0]),  64'(e0));
    chk({tag, ".lane1"},    64'(out_payload[63:32]), 64'(e1));
  endtask

  task automatic model_update();
    int         n;
    int         dq;
    logic [1:0] ev;
    n  = mq_pay.size();
    ev = model_valid();
    if (flush) begin
      mq_pay.delete();
      mq_priv.delete();
      return;
    end
    dq = 0;
    if (ev[0] && out_ready[0]) begin
      dq = 1;
      if (ev[1] && out_ready[1]) dq = 2;
    end
    for (int i = 0; i < dq; i++) begin
      void'(mq_pay.pop_front());
      void'(mq_priv.pop_front());
    end
    if ((8 - n) >= 2 && in_valid[0]) begin
      mq_pay.push_back(in_payload[31:0]);
      mq_priv.push_back(in_priv[0]);
      if (in_valid[1]) begin
        mq_pay.push_back(in_payload[63:32]);
        mq_priv.push_back(in_priv[1]);
      end
    end
  endtask

  task automatic at_neg();
    @(negedge aclk);
  endtask

  task automatic finish_cycle(input string tag);
    model_check(tag);
    model_update();
    @(posedge aclk);
    #1;
  endtask

  task automatic cycle(input string tag);
    at_neg();
    finish_cycle(tag);
  endtask

  initial begin
    // Directed vectors: enqueue A,B with consumer stalled, then drain; then
    // X, P(priv), Y issuing as three single-entry groups.
    tbl[0] = '{2'b11, 2'b00, 32'hA000_000A, 32'hB000_000B, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 4'd0};
    tbl[1] = '{2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 2'b11, 2'b00, 32'hA000_000A, 32'hB000_000B, 4'd2};
    tbl[2] = '{2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 2'b11, 2'b00, 32'hA000_000A, 32'hB000_000B, 4'd2};
    tbl[3] = '{2'b11, 2'b10, 32'hC000_000C, 32'hD000_000D, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 4'd0};
    tbl[4] = '{2'b01, 2'b00, 32'hE000_000E, 32'h0, 2'b11, 2'b01, 2'b00, 32'hC000_000C, 32'h0, 4'd2};
    tbl[5] = '{2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 2'b01, 2'b01, 32'hD000_000D, 32'h0, 4'd2};
    tbl[6] = '{2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 2'b01, 2'b00, 32'hE000_000E, 32'h0, 4'd1};
    tbl[7] = '{2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 4'd0};

    #1 areset = 1'b1;
    #2;
    chk("rst.valid",    64'(out_valid),   64'(0));
    chk("rst.payload",  out_payload,      64'(0));
    chk("rst.count",    64'(count),       64'(0));
    chk("rst.empty",    64'(empty),       64'(1));
    chk("rst.full",     64'(full),        64'(0));
    chk("rst.in_ready", 64'(in_ready),    64'(1));
    @(posedge aclk);
    @(posedge aclk);
    #3 areset = 1'b0;
    @(posedge aclk);
    #1;

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].iv, tbl[i].ip, tbl[i].p0, tbl[i].p1, tbl[i].ordy, 1'b0);
      at_neg();
      chk($sformatf("vec%0d.valid", i), 64'(out_valid),          64'(tbl[i].ev));
      chk($sformatf("vec%0d.priv", i),  64'(out_priv),           64'(tbl[i].epr));
      chk($sformatf("vec%0d.lane0", i), 64'(out_payload[31:0]),  64'(tbl[i].e0));
      chk($sformatf("vec%0d.lane1", i), 64'(out_payload[63:32]), 64'(tbl[i].e1));
      chk($sformatf("vec%0d.count", i), 64'(count),              64'(tbl[i].ecnt));
      finish_cycle($sformatf("vec%0d", i));
    end

    // Fill to capacity; in_ready drops at 7 and 8 and enqueues are refused
    // even when a dequeue happens in the same cycle.
    drive(2'b11, 2'b00, 32'h100, 32'h101, 2'b00, 1'b0); cycle("fill0");
    drive(2'b11, 2'b00, 32'h102, 32'h103, 2'b00, 1'b0); cycle("fill1");
    drive(2'b11, 2'b00, 32'h104, 32'h105, 2'b00, 1'b0); cycle("fill2");
    drive(2'b01, 2'b00, 32'h106, 32'h0,   2'b00, 1'b0); cycle("fill3");
    drive(2'b11, 2'b00, 32'h107, 32'h108, 2'b01, 1'b0);
    at_neg();
    chk("fill7.count",    64'(count),    64'(7));
    chk("fill7.in_ready", 64'(in_ready), 64'(0));
    chk("fill7.full",     64'(full),     64'(0));
    finish_cycle("fill4");
    drive(2'b11, 2'b00, 32'h109, 32'h10A, 2'b00, 1'b0);
    at_neg();
    chk("fill6.count", 64'(count), 64'(6));
    finish_cycle("fill5");
    drive(2'b11, 2'b00, 32'h10B, 32'h10C, 2'b11, 1'b0);
    at_neg();
    chk("fill8.count",    64'(count),    64'(8));
    chk("fill8.full",     64'(full),     64'(1));
    chk("fill8.in_ready", 64'(in_ready), 64'(0));
    finish_cycle("fill6");
    drive(2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    at_neg();
    chk("refused.count", 64'(count), 64'(6));
    finish_cycle("fill7");
    drive(2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
    for (int i = 0; i < 4; i++) cycle("drain");

    // Continuous 2-in/2-out streaming across many pointer wraps.
    for (int i = 0; i < 20; i++) begin
      drive(2'b11, 2'b00, 32'h200 + 32'(2*i), 32'h201 + 32'(2*i), 2'b11, 1'b0);
      at_neg();
      if (i > 0) chk($sformatf("stream%0d.count", i), 64'(count), 64'(2));
      finish_cycle("stream");
    end
    drive(2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
    cycle("stream_drain");
    cycle("stream_idle");

    // Flush with 5 entries and a concurrent enqueue; next enqueue lands at lane 0.
    drive(2'b11, 2'b00, 32'h300, 32'h301, 2'b00, 1'b0); cycle("fl0");
    drive(2'b11, 2'b00, 32'h302, 32'h303, 2'b00, 1'b0); cycle("fl1");
    drive(2'b01, 2'b00, 32'h304, 32'h0,   2'b00, 1'b0); cycle("fl2");
    drive(2'b11, 2'b00, 32'h305, 32'h306, 2'b11, 1'b1);
    at_neg();
    chk("preflush.count", 64'(count), 64'(5));
    finish_cycle("fl3");
    drive(2'b01, 2'b00, 32'h3FF, 32'h0, 2'b00, 1'b0);
    at_neg();
    chk("flush.count", 64'(count), 64'(0));
    chk("flush.empty", 64'(empty), 64'(1));
    finish_cycle("fl4");
    drive(2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    at_neg();
    chk("postflush.valid", 64'(out_valid),         64'(1));
    chk("postflush.lane0", 64'(out_payload[31:0]), 64'(32'h3FF));
    finish_cycle("fl5");
    drive(2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
    cycle("fl6");

    // Asynchronous reset in the middle of a burst.
    drive(2'b11, 2'b00, 32'h400, 32'h401, 2'b00, 1'b0); cycle("ar0");
    drive(2'b11, 2'b00, 32'h402, 32'h403, 2'b01, 1'b0); cycle("ar1");
    drive(2'b11, 2'b00, 32'h404, 32'h405, 2'b11, 1'b0);
    #2 areset = 1'b1;
    #1;
    chk("arst.valid",    64'(out_valid), 64'(0));
    chk("arst.payload",  out_payload,    64'(0));
    chk("arst.count",    64'(count),     64'(0));
    chk("arst.empty",    64'(empty),     64'(1));
    chk("arst.in_ready", 64'(in_ready),  64'(1));
    mq_pay.delete();
    mq_priv.delete();
    @(posedge aclk);
    #3 areset = 1'b0;
    cycle("ar2");
    drive(2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    at_neg();
    chk("postarst.lane0", 64'(out_payload[31:0]),  64'(32'h404));
    chk("postarst.lane1", 64'(out_payload[63:32]), 64'(32'h405));
    finish_cycle("ar3");

    // Random traffic including non-contiguous in_valid, priv and flush.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] iv;
      logic [1:0] ip;
      logic [1:0] rd;
      logic       fl;
      iv = 2'($urandom_range(0, 3));
      ip = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)};
      rd = 2'($urandom_range(0, 3));
      fl = 1'($urandom_range(0, 31) == 0);
      drive(iv, ip, $urandom, $urandom, rd, fl);
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_issue_buffer.md
DECODE_ISSUE_BUFFER -- requirements
Module: decode_issue_buffer

Interface
REQ-001 Parameter LANES, default 2: number of decode/issue lanes; legal range 1..4.
REQ-002 Parameter DEPTH, default 8: number of instruction entries; power of two, at least 2*LANES.
REQ-003 Parameter PAYLOAD_W, default 160: bits per instruction (pc, inst, uop, imm, rd/rj/rk, exception fields, packed per the shared package).
REQ-004 aclk  in  1  sole clock; all state updates on the rising edge.
REQ-005 areset  in  1  asynchronous, active-high reset.
REQ-006 flush  in  1  synchronous discard of all buffered entries.
REQ-007 in_valid  in  LANES  per-lane enqueue request; set bits are contiguous from lane 0.
REQ-008 in_priv  in  LANES  per-lane flag marking an instruction that must issue alone.
REQ-009 in_payload  in  LANES*PAYLOAD_W  lane k occupies bits [k*PAYLOAD_W +: PAYLOAD_W].
REQ-010 in_ready  out  1  buffer accepts a full LANES-wide group this cycle.
REQ-011 out_valid  out  LANES  per-lane issue-valid, contiguous from lane 0.
REQ-012 out_priv  out  LANES  priv flag of the presented entry.
REQ-013 out_payload  out  LANES*PAYLOAD_W  presented entries, oldest in lane 0.
REQ-014 out_ready  in  LANES  consumer acceptance per lane.
REQ-015 count  out  $clog2(DEPTH+1)  number of occupied entries.
REQ-016 empty / full  out  1 each  count==0 / count==DEPTH.

Function
REQ-017 Storage SHALL be a circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-018 in_ready SHALL be (DEPTH - count) >= LANES, computed from registered count only, with no bypass from same-cycle dequeue.
REQ-019 Enqueue SHALL occur when in_ready and in_valid[0]; N = popcount(in_valid) entries are written in lane order at tail, and tail advances by N.
REQ-020 A group with in_valid non-contiguous SHALL be treated as its leading contiguous prefix.
REQ-021 Entries enqueued at edge t SHALL be presentable at out_* in the cycle following edge t (1-cycle latency); no same-cycle bypass.
REQ-022 out_valid[k] SHALL be 1 iff count > k and no entry at head+j, 0<j<=k, has priv set, and the entry at head has priv clear whenever k > 0.
REQ-023 Consequences of REQ-022: a priv entry issues only in lane 0 and alone; a non-priv entry never issues in the same group as a later priv entry.
REQ-024 Dequeue count D SHALL be the length of the leading run of lanes with out_valid & out_ready; head advances by D.
REQ-025 out_payload and out_priv for any lane with out_valid=0 SHALL be driven to zero.
REQ-026 count SHALL update as count + N - D in the same edge when enqueue and dequeue coincide, including at full and at wrap-around.
REQ-027 flush SHALL zero head, tail and count at the next edge; it overrides any same-cycle enqueue and dequeue.
REQ-028 Dequeue with count==0 SHALL not occur: out_valid is all zero and pointers hold.

Reset
REQ-029 While areset is high, head, tail and count SHALL be 0, out_valid all 0, out_payload 0, empty=1, full=0, and in_ready=1.
REQ-030 Entry storage SHALL NOT be reset; REQ-025 masking guarantees deterministic outputs.
REQ-031 An areset assertion mid-operation SHALL discard all entries and enqueues in flight; the first enqueue after deassertion lands at index 0.

Structure
REQ-032 The shared package SHALL hold default LANES/DEPTH, the payload field widths (WIDTH_UOP, pc, imm, register index), and the packed payload layout.
REQ-033 One sub-module, issue_prefix_mask, SHALL compute the out_valid mask and D from count, per-entry priv flags and out_ready.

Verification (LANES=2, DEPTH=8, PAYLOAD_W=32)
REQ-034 Enqueue A,B (in_valid=11), out_ready=00 for 1 cycle, then out_ready=11: expect out_valid=11 at cycle t+1, A in lane 0, B in lane 1, count 2->0.
REQ-035 Fill 8 entries: full=1, in_ready=0 at count 7 and 8; a simultaneous dequeue of 2 with enqueue attempt is refused that cycle; count becomes 6.
REQ-036 Queue X(priv=0), P(priv=1), Y(priv=0) with out_ready=11: issue groups are {X}, {P}, {Y}, one per cycle.
REQ-037 Run 20 cycles of continuous 2-in/2-out traffic: pointers wrap past 7->0 and payload order is preserved, with count steady at 2.
REQ-038 With 5 entries, assert flush together with in_valid=11: next cycle count=0 and empty=1, and the next enqueue appears in lane 0.
REQ-039 Assert areset asynchronously mid-burst: outputs zero immediately without waiting for an edge, and behaviour is as REQ-031 after release.
